// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for the single-port SRAM pins: turns a valid/ready request
// channel into SRAM cycles and returns in-order responses through a small FIFO.
module sram_req_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int MEMD       = 2048,
  parameter int READ_LAT   = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_WMASKS-1:0] req_wmask_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_csb_o,
  output logic                  mem_web_o,
  output logic [NUM_WMASKS-1:0] mem_wmask_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_din_o,
  input  logic [DATA_WIDTH-1:0] mem_dout_i
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + READ_LAT + 1);
  localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] MEMD_C   = (ADDR_WIDTH + 1)'(MEMD);

  logic                  fire;
  logic                  oob;
  logic [READ_LAT-1:0]   vld_p;
  logic [READ_LAT-1:0]   we_p;
  logic [READ_LAT-1:0]   err_p;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] data_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  err_q;

  // Request acceptance: credit covers both in-flight tags and buffered responses
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + CNT_W'(vld_p[i]);
    end
  end

  assign outstanding = inflight + count;
  assign req_ready_o = (outstanding < DEPTH_C);
  assign fire        = req_valid_i & req_ready_o;
  assign oob         = ({1'b0, req_addr_i} >= MEMD_C);

  always_comb begin
    mem_csb_o   = 1'b1;
    mem_web_o   = 1'b1;
    mem_wmask_o = '0;
    mem_addr_o  = '0;
    mem_din_o   = '0;
    if (fire && !oob) begin
      mem_csb_o   = 1'b0;
      mem_web_o   = !req_we_i;
      mem_wmask_o = req_wmask_i;
      mem_addr_o  = req_addr_i;
      mem_din_o   = req_wdata_i;
    end
  end

  // Tag pipeline p0..p(READ_LAT-1): tracks every accepted request through the SRAM latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= fire;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    we_p[0]  <= req_we_i;
    err_p[0] <= oob;
    for (int i = 1; i < READ_LAT; i++) begin
      we_p[i]  <= we_p[i-1];
      err_p[i] <= err_p[i-1];
    end
  end

  // Response FIFO: writes and errors carry zero data so stale SRAM output never leaks
  assign push      = vld_p[READ_LAT-1];
  assign pop       = rsp_valid_o & rsp_ready_i;
  assign push_data = (we_p[READ_LAT-1] | err_p[READ_LAT-1]) ? '0 : mem_dout_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr] <= push_data;
      err_q[wr_ptr]  <= err_p[READ_LAT-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid_o = (count != '0);
  assign rsp_rdata_o = rsp_valid_o ? data_q[rd_ptr] : '0;
  assign rsp_err_o   = rsp_valid_o & err_q[rd_ptr];

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (count == DEPTH_C)));
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Randomized and directed bench for sram_req_ctrl against a transaction-level model:
// an ideal memory plus an in-order queue of expected responses with their due cycle.
module tb_sram_req_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int NM    = 4;
  localparam int MEMD  = 2048;
  localparam int RL    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req_valid, req_we, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NM-1:0] req_wmask;
  logic          req_ready_o, rsp_valid_o, rsp_err_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          mem_csb, mem_web;
  logic [NM-1:0] mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout, rd_q;

  always #5 clk = ~clk;

  sram_req_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM),
    .MEMD(MEMD), .READ_LAT(RL), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_csb_o(mem_csb), .mem_web_o(mem_web), .mem_wmask_o(mem_wmask),
    .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  // SRAM behaviour: address sampled at edge N, data on dout after edge N+1
  logic [DW-1:0] sram [1 << AW];
  always @(posedge clk) begin
    if (!mem_csb) begin
      if (!mem_web) begin
        for (int b = 0; b < NM; b++)
          if (mem_wmask[b]) sram[mem_addr][b*8 +: 8] = mem_din[b*8 +: 8];
      end else begin
        rd_q <= sram[mem_addr];
      end
    end
    mem_dout <= rd_q;
  end

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        err;
  } rsp_t;

  rsp_t          exp_q [$];
  logic [DW-1:0] ref_mem [1 << AW];
  int            outstanding = 0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of traffic; called just after a falling edge
  task automatic do_cycle(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [NM-1:0] wm,
                          input logic rr, output logic fired);
    logic exp_ready, exp_v, is_oob;
    rsp_t rec;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_wmask = wm; rsp_ready = rr;
    #1;
    exp_ready = (outstanding < DEPTH);
    is_oob    = (int'(a) >= MEMD);
    fired     = v && exp_ready;
    check_eq("req_ready", 64'(req_ready_o), 64'(exp_ready));
    if (fired && !is_oob)
      check_eq("mem_pins", {mem_csb, mem_web, mem_wmask, mem_addr, mem_din},
               {1'b0, !we, wm, a, wd});
    else
      check_eq("mem_idle", {mem_csb, mem_web, mem_wmask, mem_addr, mem_din},
               {1'b1, 1'b1, 4'h0, 12'h0, 32'h0});
    exp_v = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    check_eq("rsp_valid", 64'(rsp_valid_o), 64'(exp_v));
    if (exp_v)
      check_eq("rsp_head", {rsp_err_o, rsp_rdata_o}, {exp_q[0].err, exp_q[0].data});
    if (fired) begin
      rec.due  = cyc + RL + 1;
      rec.err  = is_oob;
      rec.data = (is_oob || we) ? '0 : ref_mem[a];
      if (!is_oob && we)
        for (int b = 0; b < NM; b++)
          if (wm[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
    end
    @(posedge clk);
    if (exp_v && rr) begin
      void'(exp_q.pop_front());
      outstanding--;
    end
    if (fired) begin
      exp_q.push_back(rec);
      outstanding++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    logic f;
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, '0, '0, rr, f);
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rst_valid", 64'(rsp_valid_o), 64'(0));
    check_eq("rst_head", {rsp_err_o, rsp_rdata_o}, 64'(0));
    check_eq("rst_ready", 64'(req_ready_o), 64'(1));
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_ni = 1'b1;
    exp_q.delete();
    outstanding = 0;
    cyc += 2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic f;
    int   k;
    int   guard;
    logic [AW-1:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    rst_ni = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    req_wmask = 0; rsp_ready = 0;
    @(negedge clk);
    apply_reset();

    // Write then read back with ack/latency checked every cycle
    do_cycle(1, 1, 12'd5, 32'h11223344, 4'hF, 1, f);
    do_cycle(1, 0, 12'd5, 32'h0, 4'h0, 1, f);
    idle(4, 1);

    // Partial write and zero-mask write
    do_cycle(1, 1, 12'd7, 32'hFFFFFFFF, 4'hF, 1, f);
    do_cycle(1, 1, 12'd7, 32'h00000000, 4'b0101, 1, f);
    do_cycle(1, 0, 12'd7, 32'h0, 4'h0, 1, f);
    do_cycle(1, 1, 12'd7, 32'h12345678, 4'h0, 1, f);
    do_cycle(1, 0, 12'd7, 32'h0, 4'h0, 1, f);
    idle(4, 1);

    // Streaming: alternating writes and reads back to back
    for (int i = 0; i < 16; i++)
      do_cycle(1, (i % 2) == 0, AW'(20 + i / 2), $urandom, 4'hF, 1, f);
    idle(4, 1);

    // Backpressure: 8 reads with responses stalled, then release
    k = 0;
    for (int i = 0; i < 8; i++) begin
      do_cycle(1, 0, AW'(20 + k), '0, '0, 0, f);
      if (f) k++;
    end
    guard = 0;
    while (k < 8 && guard < 40) begin
      do_cycle(1, 0, AW'(20 + k), '0, '0, 1, f);
      if (f) k++;
      guard++;
    end
    check_eq("bp_all_accepted", 64'(k), 64'(8));
    idle(6, 1);

    // Out-of-range accesses between valid reads
    do_cycle(1, 0, 12'd5, '0, '0, 1, f);
    do_cycle(1, 0, 12'd2048, '0, '0, 1, f);
    do_cycle(1, 0, 12'd7, '0, '0, 1, f);
    do_cycle(1, 1, 12'd4095, 32'hDEADBEEF, 4'hF, 1, f);
    do_cycle(1, 0, 12'd2047, '0, '0, 1, f);
    idle(5, 1);

    // Reset with one response buffered and two reads in flight
    do_cycle(1, 0, 12'd5, '0, '0, 0, f);
    do_cycle(1, 0, 12'd7, '0, '0, 0, f);
    do_cycle(1, 0, 12'd20, '0, '0, 0, f);
    apply_reset();
    idle(3, 1);
    do_cycle(1, 0, 12'd5, '0, '0, 1, f);
    idle(4, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 12'd2047;
        1:       a = 12'd2048 + AW'($urandom_range(0, 2047));
        default: a = AW'($urandom_range(0, 15));
      endcase
      do_cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), a, $urandom,
               NM'($urandom), ($urandom_range(0, 3) != 0), f);
    end
    idle(8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
Initiator-side controller that drives the single-port read/write pins (port 0) of the banked SRAM wrapper. It turns a valid/ready request channel into SRAM access cycles and returns in-order responses. It tracks the fixed SRAM read latency and buffers returned data in a response FIFO, so backpressure on the response channel never drops data. It sits between the core/bus-side memory adapter and the SRAM wrapper.

Parameters:
ADDR_WIDTH, 11, word address width
DATA_WIDTH, 32, data width
NUM_WMASKS, 4, byte write-enable lanes (DATA_WIDTH/8)
MEMD, 2048, implemented words; addresses >= MEMD are out of range
READ_LAT, 2, edges from accepted request to valid mem_dout sample
RSP_DEPTH, 4, response FIFO entries; must be >= READ_LAT+1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  word address
req_wdata_i  in  DATA_WIDTH  write data
req_wmask_i  in  NUM_WMASKS  byte mask
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes/errors)
rsp_err_o  out  1  out-of-range access
mem_csb_o  out  1  SRAM chip select, active low
mem_web_o  out  1  SRAM write enable, active low
mem_wmask_o  out  NUM_WMASKS  SRAM byte mask
mem_addr_o  out  ADDR_WIDTH  SRAM address
mem_din_o  out  DATA_WIDTH  SRAM write data
mem_dout_i  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset is asynchronous and active-low: in-flight pipeline cleared, FIFO empty, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. Requests in flight at reset are dropped with no response.
- outstanding = in-flight count + FIFO count. req_ready_o = (outstanding < RSP_DEPTH). No same-cycle pop credit. It is 1 immediately after reset.
- fire = req_valid_i & req_ready_o. oob = (req_addr_i >= MEMD).
- SRAM pins are combinational from the request. On fire & !oob: mem_csb_o=0, mem_web_o=!req_we_i, and addr/din/wmask pass the request fields through. Otherwise: csb=1, web=1, addr/din/wmask=0. The SRAM samples at the same edge as fire.
- Every fire, including writes and oob accesses, enters a READ_LAT-deep tag shift register {valid, we, err}. This preserves strict ordering.
- At edge N+READ_LAT after fire at edge N, the tag is pushed into the FIFO:
  - read, not err: data=mem_dout_i, err=0
  - write: data=0, err=0
  - err: data=0, err=1, and the SRAM is untouched
- FIFO: registered outputs. rsp_valid_o = (count != 0). Head is shown on rsp_rdata_o/rsp_err_o. Pop on rsp_valid_o & rsp_ready_i.
- Push and pop in the same cycle: count unchanged. Read/write pointers wrap modulo RSP_DEPTH.
- Sizing guarantees a push never finds the FIFO full. An assertion flags overflow.
- Throughput: one request per cycle sustained while rsp_ready_i=1. Minimum latency from fire to rsp_valid_o is READ_LAT edges.
- A write with wmask=0 still issues (csb=0, web=0) and returns an ack.
- rsp_valid_o, once high, holds stable with unchanged data until popped.

Test Plan:
- Write 0x11223344 at addr 5, then read addr 5 (rsp_ready=1) -> write ack (err=0, rdata=0) exactly 2 edges after its fire; read response 0x11223344, 2 edges after its fire.
- Partial write: init addr 7=0xFFFFFFFF, then write 0x00000000 with wmask=4'b0101 and read back -> 0xFF00FF00. mem_web_o=0 only in the write fire cycle.
- Backpressure: rsp_ready=0, issue 8 back-to-back reads -> exactly 4 accepted, req_ready_o=0 thereafter. Raise rsp_ready -> 4 correct responses in order, then the remaining 4 accepted. No loss or duplication.
- Out of range: read addr 2048 with MEMD=2048 -> mem_csb_o stays 1, response err=1, rdata=0, in order between surrounding valid reads.
- Streaming: 16 consecutive alternating writes/reads with rsp_ready=1 -> req_ready_o never drops, 16 responses on 16 consecutive cycles.
- Reset mid-operation: assert rst_ni low with 2 reads in flight and 1 buffered -> rsp_valid_o=0 asynchronously, no stale responses after release, req_ready_o=1, and the next read returns correctly.
